multicycle_ctrl: RTL and testbench

- Multicycle sequencer for the 8-bit processor.
- Drives the shared ALU, register file, PC and the single unified memory port across FETCH/DECODE/EXEC/MEM/WB states, instead of single-cycle decode.
- Decodes the 3-bit opcode set: lw 000, sw 001, add 010, addi 011, sub 100, jmp 101; 110/111 are illegal.
- Stalls on a memory-ready handshake and flags memory time-outs.

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between the multicycle sequencer and the datapath
`timescale 1ns/1ps
interface multicycle_ctrl_if;
  logic       run;
  logic [2:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCSrc;
  logic       IorD;
  logic       IRWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrc;
  logic [1:0] ALUOp;
  logic [2:0] state;
  logic       instr_done;
  logic       illegal;
  logic       bus_err;

  modport master (
    output run, opcode, mem_ready,
    input  PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
    input  RegDst, RegWrite, ALUSrc, ALUOp, state, instr_done, illegal, bus_err
  );

  modport slave (
    input  run, opcode, mem_ready,
    output PCWrite, PCSrc, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
    output RegDst, RegWrite, ALUSrc, ALUOp, state, instr_done, illegal, bus_err
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 8-bit processor
`timescale 1ns/1ps
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input logic              clk,
  input logic              reset,
  multicycle_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [2:0] OP_LW   = 3'd0;
  localparam logic [2:0] OP_SW   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_JMP  = 3'd5;

  // Last wait count at which a still-pending access is declared timed out
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_bus_err;
  logic             w_mem_state;
  logic             w_timeout;
  logic             w_cnt_clr;
  logic             w_done;

  // A memory access is pending in FETCH and MEM; it times out when the budget is spent without mem_ready
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_timeout   = w_mem_state && !bus.mem_ready && (r_wait_cnt == W_LAST);
  // Any state change (which covers entry to FETCH/MEM) or a completed access restarts the count
  assign w_cnt_clr   = bus.mem_ready || w_timeout || (w_next != r_state);

  assign bus.state   = r_state;
  assign bus.bus_err = r_bus_err;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode latch in DECODE and sticky bus-error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= 3'd0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_op <= bus.opcode;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  // Memory wait counter, advancing only while an access is outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_wait_cnt <= '0;
    end else if (w_mem_state) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Next-state and control strobes, decoded from state, latched opcode and mem_ready
  always_comb begin
    w_next         = r_state;
    w_done         = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.PCSrc      = 1'b0;
    bus.IorD       = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegDst     = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrc     = 1'b0;
    bus.ALUOp      = 2'b00;
    bus.illegal    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run && !r_bus_err) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        bus.MemRead = 1'b1;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          w_next      = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_DECODE: begin
        // op_q is not loaded yet, so the live opcode decides this cycle
        if (bus.opcode == OP_JMP) begin
          bus.PCWrite = 1'b1;
          bus.PCSrc   = 1'b1;
          w_done      = 1'b1;
        end else if (bus.opcode[2:1] == 2'b11) begin
          bus.illegal = 1'b1;
          w_done      = 1'b1;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.ALUOp  = (r_op == OP_SUB) ? 2'b10 : 2'b00;
        bus.ALUSrc = (r_op == OP_LW) || (r_op == OP_SW) || (r_op == OP_ADDI);
        w_next     = ((r_op == OP_LW) || (r_op == OP_SW)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.IorD     = 1'b1;
        bus.ALUSrc   = 1'b1;
        bus.MemRead  = (r_op == OP_LW);
        bus.MemWrite = (r_op == OP_SW);
        if (bus.mem_ready) begin
          if (r_op == OP_SW) begin
            w_done = 1'b1;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        w_done       = 1'b1;
        if (r_op == OP_LW) begin
          bus.MemtoReg = 1'b1;
        end else if (r_op == OP_ADDI) begin
          bus.ALUSrc = 1'b1;
        end else if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
          bus.RegDst = 1'b1;
          bus.ALUOp  = (r_op == OP_SUB) ? 2'b10 : 2'b00;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_done) begin
      w_next = bus.run ? S_FETCH : S_IDLE;
    end
    bus.instr_done = w_done;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with randomized instruction streams
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       pcw;
    logic       pcsrc;
    logic       iord;
    logic       irw;
    logic       mrd;
    logic       mwr;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asrc;
    logic [1:0] aluop;
    logic       done;
    logic       ill;
    logic       berr;
  } ctrl_t;

  typedef struct {
    logic  chk;
    ctrl_t e15;
    ctrl_t e4;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       mem_ready = 1'b1;

  int    n_checks = 0;
  int    n_fail = 0;
  exp_t  exp_q[$];
  int    lat_q[$];
  int    lat_cnt = 0;
  exp_t  mx;
  int    ml;
  bit    in_idle = 1'b1;
  ctrl_t a15;
  ctrl_t a4;

  always #5 clk = ~clk;

  multicycle_ctrl_if b15 ();
  multicycle_ctrl_if b4 ();

  assign b15.run       = run;
  assign b15.opcode    = opcode;
  assign b15.mem_ready = mem_ready;
  assign b4.run        = run;
  assign b4.opcode     = opcode;
  assign b4.mem_ready  = mem_ready;

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut15 (.clk(clk), .reset(reset), .bus(b15));
  multicycle_ctrl #(.MEM_TIMEOUT(4),  .CNT_W(8)) dut4  (.clk(clk), .reset(reset), .bus(b4));

  assign a15 = {b15.state, b15.PCWrite, b15.PCSrc, b15.IorD, b15.IRWrite, b15.MemRead,
                b15.MemWrite, b15.MemtoReg, b15.RegDst, b15.RegWrite, b15.ALUSrc,
                b15.ALUOp, b15.instr_done, b15.illegal, b15.bus_err};
  assign a4  = {b4.state, b4.PCWrite, b4.PCSrc, b4.IorD, b4.IRWrite, b4.MemRead,
                b4.MemWrite, b4.MemtoReg, b4.RegDst, b4.RegWrite, b4.ALUSrc,
                b4.ALUOp, b4.instr_done, b4.illegal, b4.bus_err};

  // Monitor: per-cycle control vectors and per-instruction latency
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mx = exp_q.pop_front();
      if (mx.chk) begin
        n_checks++;
        if (a15 !== mx.e15) begin
          n_fail++;
          $display("FAIL ctrl_t15 t=%0t got=%h exp=%h", $time, a15, mx.e15);
        end
        n_checks++;
        if (a4 !== mx.e4) begin
          n_fail++;
          $display("FAIL ctrl_t4 t=%0t got=%h exp=%h", $time, a4, mx.e4);
        end
      end
    end
    if (a15.state == 3'd0) lat_cnt = 0;
    else lat_cnt++;
    if (a15.done === 1'b1) begin
      n_checks++;
      if (lat_q.size() == 0) begin
        n_fail++;
        $display("FAIL latency t=%0t got=unexpected instr_done exp=none", $time);
      end else begin
        ml = lat_q.pop_front();
        if (lat_cnt != ml) begin
          n_fail++;
          $display("FAIL latency t=%0t got=%0d exp=%0d", $time, lat_cnt, ml);
        end
      end
      lat_cnt = 0;
    end
  end

  function automatic logic [2:0] rop();
    return 3'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic step(input logic rst, input logic rn, input logic [2:0] opc, input logic mr,
                      input logic chk, input ctrl_t e15, input ctrl_t e4);
    exp_t x;
    @(posedge clk);
    #1;
    reset     = rst;
    run       = rn;
    opcode    = opc;
    mem_ready = mr;
    x.chk = chk;
    x.e15 = e15;
    x.e4  = e4;
    exp_q.push_back(x);
  endtask

  task automatic stepb(input logic rst, input logic rn, input logic [2:0] opc, input logic mr,
                       input ctrl_t e);
    step(rst, rn, opc, mr, 1'b1, e, e);
  endtask

  task automatic idle(input logic rn);
    ctrl_t e;
    e = '0;
    stepb(1'b0, rn, rop(), rbit(), e);
    in_idle = !rn;
  endtask

  // One instruction from FETCH to its last cycle, expanded into the expected phase sequence
  task automatic instr(input logic [2:0] op, input int fw, input int mw, input logic run_end,
                       input logic abort_in_mem);
    ctrl_t e;
    bit    is_jmp, is_ill, is_mem;
    int    lat;
    is_jmp = (op == 3'd5);
    is_ill = (op >= 3'd6);
    is_mem = (op <= 3'd1);
    if (in_idle) idle(1'b1);
    lat = (op == 3'd0) ? 5 : ((is_jmp || is_ill) ? 2 : 4);
    lat = lat + fw + (is_mem ? mw : 0);
    if (!abort_in_mem) lat_q.push_back(lat);
    for (int i = 0; i < fw; i++) begin
      e = '0; e.state = 3'd1; e.mrd = 1'b1;
      stepb(1'b0, rbit(), rop(), 1'b0, e);
    end
    e = '0; e.state = 3'd1; e.mrd = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
    stepb(1'b0, rbit(), rop(), 1'b1, e);
    e = '0; e.state = 3'd2;
    if (is_jmp) begin
      e.pcw = 1'b1; e.pcsrc = 1'b1; e.done = 1'b1;
    end else if (is_ill) begin
      e.ill = 1'b1; e.done = 1'b1;
    end
    stepb(1'b0, (is_jmp || is_ill) ? run_end : rbit(), op, rbit(), e);
    if (is_jmp || is_ill) begin
      in_idle = !run_end;
      return;
    end
    e = '0; e.state = 3'd3;
    e.aluop = (op == 3'd4) ? 2'b10 : 2'b00;
    e.asrc  = (op == 3'd0) || (op == 3'd1) || (op == 3'd3);
    stepb(1'b0, rbit(), rop(), rbit(), e);
    if (is_mem) begin
      e = '0; e.state = 3'd4; e.iord = 1'b1; e.asrc = 1'b1;
      e.mrd = (op == 3'd0); e.mwr = (op == 3'd1);
      for (int i = 0; i < mw; i++) begin
        if (abort_in_mem && (i == mw - 1)) begin
          stepb(1'b1, 1'b1, rop(), 1'b0, e);
          in_idle = 1'b1;
          return;
        end
        stepb(1'b0, rbit(), rop(), 1'b0, e);
      end
      if (op == 3'd1) begin
        e.done = 1'b1;
        stepb(1'b0, run_end, rop(), 1'b1, e);
        in_idle = !run_end;
        return;
      end
      stepb(1'b0, rbit(), rop(), 1'b1, e);
    end
    e = '0; e.state = 3'd5; e.rw = 1'b1; e.done = 1'b1;
    if (op == 3'd0) begin
      e.m2r = 1'b1;
    end else if (op == 3'd3) begin
      e.asrc = 1'b1;
    end else begin
      e.rdst  = 1'b1;
      e.aluop = (op == 3'd4) ? 2'b10 : 2'b00;
    end
    stepb(1'b0, run_end, rop(), rbit(), e);
    in_idle = !run_end;
  endtask

  // FETCH starved of mem_ready: each instance errors out after its own budget of wait cycles
  task automatic timeout_test();
    ctrl_t fw_e, err_e, e15, e4;
    if (in_idle) idle(1'b1);
    fw_e  = '0; fw_e.state = 3'd1; fw_e.mrd = 1'b1;
    err_e = '0; err_e.berr = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      e15 = (i <= 15) ? fw_e : err_e;
      e4  = (i <= 4)  ? fw_e : err_e;
      step(1'b0, 1'b1, rop(), 1'b0, 1'b1, e15, e4);
    end
    step(1'b1, 1'b1, rop(), 1'b0, 1'b1, err_e, err_e);
    idle(1'b1);
  endtask

  initial begin
    ctrl_t z;
    z = '0;
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, z, z);
    step(1'b1, 1'b1, 3'd0, 1'b1, 1'b1, z, z);
    in_idle = 1'b1;

    instr(3'd2, 0, 0, 1'b1, 1'b0);
    instr(3'd0, 0, 0, 1'b1, 1'b0);
    instr(3'd1, 0, 0, 1'b1, 1'b0);
    instr(3'd5, 0, 0, 1'b1, 1'b0);
    instr(3'd4, 0, 0, 1'b1, 1'b0);
    instr(3'd3, 0, 0, 1'b1, 1'b0);
    instr(3'd0, 0, 3, 1'b1, 1'b0);
    instr(3'd7, 0, 0, 1'b1, 1'b0);
    instr(3'd6, 1, 0, 1'b1, 1'b0);
    instr(3'd2, 0, 0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    instr(3'd1, 1, 2, 1'b1, 1'b1);
    timeout_test();

    for (int n = 0; n < 80; n++) begin
      if (in_idle) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) idle(1'b0);
      end
      instr(rop(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), 1'b0);
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (lat_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_instr got=%0d exp=0", lat_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
